// File: rtl/addfloat_arbiter.sv
// addfloat_arbiter: shares one pipelined single-precision AddFloat core
// between N_REQ requesters. One operand pair is issued per ce-cycle; a tag
// pipeline matched to the adder latency carries the requester index so each
// registered sum is strobed back to the requester that issued it.
// Optional build macro: ADDFLOAT_ARB_FIXED_PRIO_EN (fixed priority, lowest
// index wins, no round-robin pointer). Default build is round robin.
module addfloat_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 5,
  parameter int ID_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [32*N_REQ-1:0]   i_opa,
  input  logic [32*N_REQ-1:0]   i_opb,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [31:0]           o_add_a,
  output logic [31:0]           o_add_b,
  input  logic [31:0]           i_add_result,
  output logic [N_REQ-1:0]      o_res_valid,
  output logic [31:0]           o_res_data,
  output logic                  o_busy
);

  localparam int DATA_W = 32;

  logic            found;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cand;

  logic [DATA_W-1:0] add_a_q, add_a_d;
  logic [DATA_W-1:0] add_b_q, add_b_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]   tag_id_q [LATENCY];
  logic [ID_W-1:0]   tag_id_d [LATENCY];
  logic [N_REQ-1:0]  res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

`ifdef ADDFLOAT_ARB_FIXED_PRIO_EN
  // Fixed-priority grant search: scan downward so the lowest requester wins.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    if (ce && !reset) begin
      for (int j = N_REQ - 1; j >= 0; j--) begin
        cand = ID_W'(j);
        if (i_req[cand]) begin
          found  = 1'b1;
          gnt_id = cand;
        end
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Round-robin grant search starting at the pointer, wrapping past N_REQ-1.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    ptr_d  = ptr_q;
    if (ce && !reset) begin
      for (int j = 0; j < N_REQ; j++) begin
        cand = ID_W'((int'(ptr_q) + j) % N_REQ);
        if (!found && i_req[cand]) begin
          found  = 1'b1;
          gnt_id = cand;
        end
      end
      if (found) begin
        ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  // Pointer register: moves just past the winner on every granted ce-edge.
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  // One-hot grant decode; found already folds in ce and reset.
  always_comb begin
    o_gnt = '0;
    if (found) o_gnt[gnt_id] = 1'b1;
  end

  // Next-state for issue, tag pipeline and delivery; everything holds when ce=0.
  always_comb begin
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    tag_vld_d   = tag_vld_q;
    tag_id_d    = tag_id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (ce) begin
      // Stage p0: operand registers feeding the adder, tag enters the pipe.
      if (found) begin
        add_a_d = i_opa[DATA_W*gnt_id +: DATA_W];
        add_b_d = i_opb[DATA_W*gnt_id +: DATA_W];
      end
      tag_vld_d   = {tag_vld_q[LATENCY-2:0], found};
      tag_id_d[0] = gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_id_d[i] = tag_id_q[i-1];
      end
      // Final stage: adder output is valid alongside the last tag, register it.
      res_valid_d = '0;
      if (tag_vld_q[LATENCY-1]) begin
        res_valid_d[tag_id_q[LATENCY-1]] = 1'b1;
        res_data_d                       = i_add_result;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      tag_vld_q   <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      tag_vld_q   <= tag_vld_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Requester IDs are only meaningful under their valid bits, so no reset.
  always_ff @(posedge clock) begin
    tag_id_q <= tag_id_d;
  end

  assign o_add_a     = add_a_q;
  assign o_add_b     = add_b_q;
  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_busy      = (|tag_vld_q) || (|res_valid_q);

endmodule

// File: tb/tb_addfloat_arbiter.sv
// Testbench for addfloat_arbiter: a cycle-by-cycle vector table plus short
// hand-written sequences for reset and arbitration order. The adder core is
// modelled as a ce-gated delay line with a lookup for the float test values.
module tb_addfloat_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            ce;
  logic [NR-1:0]   i_req;
  logic [32*NR-1:0] i_opa, i_opb;
  logic [NR-1:0]   o_gnt;
  logic [31:0]     o_add_a, o_add_b;
  logic [31:0]     i_add_result;
  logic [NR-1:0]   o_res_valid;
  logic [31:0]     o_res_data;
  logic            o_busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  addfloat_arbiter #(.N_REQ(NR), .LATENCY(LAT), .ID_W(2)) dut (
    .clock(clock), .reset(reset), .ce(ce), .i_req(i_req),
    .i_opa(i_opa), .i_opb(i_opb), .o_gnt(o_gnt),
    .o_add_a(o_add_a), .o_add_b(o_add_b), .i_add_result(i_add_result),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_busy(o_busy)
  );

  // Adder stand-in: known float sums for the named cases, integer sum otherwise.
  function automatic logic [31:0] mock_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3f800000 && b == 32'h3fa66666) return 32'h40133333;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return a + b;
  endfunction

  // Result appears LAT ce-edges after the operand registers load.
  logic [31:0] pipe [LAT-1];
  always @(posedge clock) begin
    if (ce) begin
      pipe[0] <= mock_add(o_add_a, o_add_b);
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign i_add_result = pipe[LAT-2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] lane(input int k, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[32*k +: 32] = v;
    return r;
  endfunction

  typedef struct {
    logic [3:0]   req;
    logic         ce;
    logic [127:0] opa;
    logic [127:0] opb;
    logic [3:0]   gnt;
    logic [3:0]   rv;
    logic [31:0]  rd;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] req, input logic c, input logic [127:0] a,
                     input logic [127:0] b, input logic [3:0] g, input logic [3:0] rv,
                     input logic [31:0] rd, input logic bz);
    vec_t v;
    v.req = req; v.ce = c; v.opa = a; v.opb = b;
    v.gnt = g; v.rv = rv; v.rd = rd; v.busy = bz;
    vecs.push_back(v);
  endtask

  logic [127:0] a2, b2, z;
  logic [3:0]   alt_exp [4];

  initial begin
    z  = '0;
    a2 = {32'h40000000, 32'h30000000, 32'h20000000, 32'h10000000};
    b2 = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};

    // All four requesting: grants 0,1,2,3,0 then results in the same order.
    for (int i = 0; i < 5; i++) add(4'hF, 1, a2, b2, 4'(1 << (i % 4)), 0, 0, i != 0);
    add(0, 1, z, z, 0, 0, 0, 1);
    add(0, 1, z, z, 0, 4'h1, 32'h10000001, 1);
    add(0, 1, z, z, 0, 4'h2, 32'h20000002, 1);
    add(0, 1, z, z, 0, 4'h4, 32'h30000003, 1);
    add(0, 1, z, z, 0, 4'h8, 32'h40000004, 1);
    add(0, 1, z, z, 0, 4'h1, 32'h10000001, 1);
    add(0, 1, z, z, 0, 0, 0, 0);
    // Single op from requester 0: 1.0 + 1.3.
    add(4'h1, 1, lane(0, 32'h3f800000), lane(0, 32'h3fa66666), 4'h1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, z, z, 0, 0, 0, 1);
    add(0, 1, z, z, 0, 4'h1, 32'h40133333, 1);
    add(0, 1, z, z, 0, 0, 0, 0);
    // Requester 1: 2.0 + 2.0 with ce low three cycles; req0 blocked while ce low.
    add(4'h2, 1, lane(1, 32'h40000000), lane(1, 32'h40000000), 4'h2, 0, 0, 0);
    add(0, 1, z, z, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(4'h1, 0, lane(0, 32'h10000000), lane(0, 32'h1), 0, 0, 0, 1);
    add(4'h1, 1, lane(0, 32'h10000000), lane(0, 32'h1), 4'h1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, z, z, 0, 0, 0, 1);
    add(0, 1, z, z, 0, 4'h2, 32'h40800000, 1);
    add(0, 1, z, z, 0, 0, 0, 1);
    add(0, 1, z, z, 0, 4'h1, 32'h10000001, 1);
    // Requester 2 back-to-back with new operands each cycle.
    add(4'h4, 1, lane(2, 32'h01000000), lane(2, 32'h10), 4'h4, 0, 0, 0);
    add(4'h4, 1, lane(2, 32'h02000000), lane(2, 32'h20), 4'h4, 0, 0, 1);
    add(4'h4, 1, lane(2, 32'h03000000), lane(2, 32'h30), 4'h4, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, z, z, 0, 0, 0, 1);
    add(0, 1, z, z, 0, 4'h4, 32'h01000010, 1);
    add(0, 1, z, z, 0, 4'h4, 32'h02000020, 1);
    // Strobe is held while ce is low.
    add(0, 0, z, z, 0, 4'h4, 32'h03000030, 1);
    add(0, 1, z, z, 0, 4'h4, 32'h03000030, 1);
    add(0, 1, z, z, 0, 0, 0, 0);

    // Power-on reset with everyone requesting: no grant while in reset.
    reset = 1'b1; ce = 1'b1; i_req = 4'hF; i_opa = a2; i_opb = b2;
    @(negedge clock);
    chk("gnt_in_reset", 32'(o_gnt), 0);
    @(negedge clock);
    reset = 1'b0; i_req = '0;
    #1;
    chk("reset_rv", 32'(o_res_valid), 0);
    chk("reset_rd", o_res_data, 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_add_a", o_add_a, 0);
    @(negedge clock);

`ifndef ADDFLOAT_ARB_FIXED_PRIO_EN
    for (int r = 0; r < vecs.size(); r++) begin
      i_req = vecs[r].req; ce = vecs[r].ce; i_opa = vecs[r].opa; i_opb = vecs[r].opb;
      #1;
      chk($sformatf("row%0d_gnt", r), 32'(o_gnt), 32'(vecs[r].gnt));
      chk($sformatf("row%0d_rv", r), 32'(o_res_valid), 32'(vecs[r].rv));
      if (vecs[r].rv != 0) chk($sformatf("row%0d_rd", r), o_res_data, vecs[r].rd);
      chk($sformatf("row%0d_busy", r), 32'(o_busy), 32'(vecs[r].busy));
      @(negedge clock);
    end
`endif

    // Reset two cycles after an issue: that op must never be delivered.
    ce = 1'b1; i_req = 4'h1;
    i_opa = lane(0, 32'h05000000); i_opb = lane(0, 32'h5);
    #1;
    chk("rst_issue_gnt", 32'(o_gnt), 1);
    @(negedge clock);
    i_req = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; i_req = 4'h1;
    #1;
    chk("rst_gnt_blocked", 32'(o_gnt), 0);
    chk("rst_busy_before", 32'(o_busy), 1);
    @(negedge clock);
    reset = 1'b0; i_req = '0;
    #1;
    chk("rst_busy_after", 32'(o_busy), 0);
    chk("rst_add_a", o_add_a, 0);
    chk("rst_add_b", o_add_b, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_no_rv%0d", i), 32'(o_res_valid), 0);
      @(negedge clock);
      #1;
    end

    // Requesters 0 and 3 held together: arbitration order and result routing.
`ifdef ADDFLOAT_ARB_FIXED_PRIO_EN
    alt_exp = '{4'h1, 4'h1, 4'h1, 4'h1};
`else
    alt_exp = '{4'h1, 4'h8, 4'h1, 4'h8};
`endif
    i_opa = lane(0, 32'h06000000) | lane(3, 32'h07000000);
    i_opb = lane(0, 32'h6) | lane(3, 32'h7);
    for (int r = 0; r < 12; r++) begin
      i_req = (r < 4) ? 4'h9 : 4'h0;
      #1;
      if (r < 4) chk($sformatf("alt%0d_gnt", r), 32'(o_gnt), 32'(alt_exp[r]));
      if (r >= 6 && r < 10) begin
        chk($sformatf("alt%0d_rv", r), 32'(o_res_valid), 32'(alt_exp[r-6]));
        chk($sformatf("alt%0d_rd", r), o_res_data,
            (alt_exp[r-6] == 4'h1) ? 32'h06000006 : 32'h07000007);
      end else begin
        chk($sformatf("alt%0d_rv", r), 32'(o_res_valid), 0);
      end
      if (r == 11) chk("alt_busy_end", 32'(o_busy), 0);
      @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
